// File: rtl/change_dispenser.sv
// Coin hopper payout controller: greedy 50/10/5 coin requests with ack handshake and timeouts.
// Optional per-denomination coin tallies when COIN_TALLY_EN is defined.
module change_dispenser #(
  parameter int ACK_TIMEOUT = 250,
  parameter int GAP_CYCLES  = 25,
  parameter int MAX_AMOUNT  = 995
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] amount,
  input  logic       coin_ack,
  input  logic       clear_fault,
  output logic [2:0] coin_req,
  output logic [9:0] remaining,
  output logic       busy,
  output logic       done,
  output logic       reject,
  output logic       fault
`ifdef COIN_TALLY_EN
  ,
  output logic [7:0] tally_50,
  output logic [7:0] tally_10,
  output logic [7:0] tally_5
`endif
);

  localparam int TMAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);
  localparam logic [9:0]    MAX_AMT  = 10'(MAX_AMOUNT);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_REQ, S_REL, S_GAP, S_DONE, S_FAULT
  } state_t;

  state_t        state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [2:0]    coin_req_d;
  logic [9:0]    remaining_d;
  logic          busy_d, done_d, reject_d, fault_d;
  logic [9:0]    denom;
  logic          amount_ok;

  assign amount_ok = ((amount % 10'd5) == 10'd0) && (amount <= MAX_AMT);

  always_comb begin
    case (coin_req)
      3'b100:  denom = 10'd50;
      3'b010:  denom = 10'd10;
      3'b001:  denom = 10'd5;
      default: denom = 10'd0;
    endcase
  end

  always_comb begin
    state_d     = state;
    timer_d     = timer;
    coin_req_d  = coin_req;
    remaining_d = remaining;
    busy_d      = busy;
    done_d      = 1'b0;
    reject_d    = 1'b0;
    fault_d     = fault;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (amount_ok) begin
            remaining_d = amount;
            busy_d      = 1'b1;
            state_d     = S_SELECT;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      S_SELECT: begin
        if (remaining == 10'd0) begin
          state_d = S_DONE;
        end else begin
          if (remaining >= 10'd50)      coin_req_d = 3'b100;
          else if (remaining >= 10'd10) coin_req_d = 3'b010;
          else                          coin_req_d = 3'b001;
          timer_d = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (coin_ack) begin
          // greedy selection guarantees remaining >= denom
          remaining_d = remaining - denom;
          coin_req_d  = 3'b000;
          timer_d     = '0;
          state_d     = S_REL;
        end else if (timer == ACK_LAST) begin
          coin_req_d = 3'b000;
          fault_d    = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_FAULT;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      S_REL: begin
        if (!coin_ack) begin
          timer_d = '0;
          state_d = S_GAP;
        end else if (timer == ACK_LAST) begin
          fault_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_FAULT;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      S_GAP: begin
        if (timer == GAP_LAST) state_d = S_SELECT;
        else                   timer_d = timer + 1'b1;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_FAULT: begin
        // unpaid amount stays visible so upstream can restart with it
        if (clear_fault) begin
          fault_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      timer     <= '0;
      coin_req  <= 3'b000;
      remaining <= 10'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      reject    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_d;
      timer     <= timer_d;
      coin_req  <= coin_req_d;
      remaining <= remaining_d;
      busy      <= busy_d;
      done      <= done_d;
      reject    <= reject_d;
      fault     <= fault_d;
    end
  end

`ifdef COIN_TALLY_EN
  logic coin_taken;
  assign coin_taken = (state == S_REQ) && coin_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tally_50 <= 8'd0;
      tally_10 <= 8'd0;
      tally_5  <= 8'd0;
    end else if (coin_taken) begin
      if (coin_req[2] && tally_50 != 8'hff) tally_50 <= tally_50 + 8'd1;
      if (coin_req[1] && tally_10 != 8'hff) tally_10 <= tally_10 + 8'd1;
      if (coin_req[0] && tally_5  != 8'hff) tally_5  <= tally_5  + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser; acts as the coin hopper.
module tb_change_dispenser;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [9:0] amount = 10'd0;
  logic       coin_ack = 1'b0;
  logic       clear_fault = 1'b0;
  logic [2:0] coin_req;
  logic [9:0] remaining;
  logic       busy, done, reject, fault;
`ifdef COIN_TALLY_EN
  logic [7:0] tally_50, tally_10, tally_5;
`endif

  int checks = 0;
  int errors = 0;

  change_dispenser dut (
    .clk(clk), .reset(reset), .start(start), .amount(amount),
    .coin_ack(coin_ack), .clear_fault(clear_fault),
    .coin_req(coin_req), .remaining(remaining), .busy(busy),
    .done(done), .reject(reject), .fault(fault)
`ifdef COIN_TALLY_EN
    , .tally_50(tally_50), .tally_10(tally_10), .tally_5(tally_5)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // polls up to 60 cycles for a coin request; flags a timeout as a failure
  task automatic wait_req(input string name);
    int n = 0;
    while (coin_req == 3'b000 && n < 60) begin step(); n++; end
    checks++;
    if (coin_req == 3'b000) begin
      errors++; $display("FAIL %s wait coin_req: timed out after %0d cycles", name, n);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++; if (coin_req !== 3'b000) begin errors++; $display("FAIL reset coin_req: got %b want 000", coin_req); end
    checks++; if (remaining !== 10'd0) begin errors++; $display("FAIL reset remaining: got %0d want 0", remaining); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
    checks++; if (reject !== 1'b0) begin errors++; $display("FAIL reset reject: got %b want 0", reject); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset fault: got %b want 0", fault); end
    @(negedge clk) reset = 1'b1;
    step();
  endtask

  task automatic test_pay85();
    logic [2:0] exp_coin [5];
    logic [9:0] exp_rem  [5];
    int ndone = 0;
    exp_coin = '{3'b100, 3'b010, 3'b010, 3'b010, 3'b001};
    exp_rem  = '{10'd35, 10'd25, 10'd15, 10'd5, 10'd0};
    amount = 10'd85; start = 1'b1;
    step(); start = 1'b0;
    checks++; if (busy !== 1'b1 || remaining !== 10'd85 || coin_req !== 3'b000) begin
      errors++; $display("FAIL pay85 accept: busy %b rem %0d req %b want 1/85/000", busy, remaining, coin_req); end
    step();
    checks++; if (coin_req !== 3'b100) begin errors++; $display("FAIL pay85 first req latency: got %b want 100", coin_req); end
    for (int k = 0; k < 5; k++) begin
      wait_req("pay85");
      checks++; if (coin_req !== exp_coin[k]) begin errors++; $display("FAIL pay85 coin %0d: got %b want %b", k, coin_req, exp_coin[k]); end
      step(); step(); step();
      checks++; if (coin_req !== exp_coin[k]) begin errors++; $display("FAIL pay85 hold %0d: got %b want %b", k, coin_req, exp_coin[k]); end
      coin_ack = 1'b1;
      step();
      checks++; if (remaining !== exp_rem[k] || coin_req !== 3'b000) begin
        errors++; $display("FAIL pay85 ack %0d: rem %0d req %b want %0d/000", k, remaining, coin_req, exp_rem[k]); end
      coin_ack = 1'b0;
      step();
    end
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      step();
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL pay85 done count: got %0d want 1", ndone); end
    checks++; if (busy !== 1'b0 || remaining !== 10'd0) begin errors++; $display("FAIL pay85 end: busy %b rem %0d want 0/0", busy, remaining); end
  endtask

  task automatic test_zero();
    amount = 10'd0; start = 1'b1;
    step(); start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL zero c0: busy %b done %b want 1/0", busy, done); end
    step();
    checks++; if (busy !== 1'b1 || done !== 1'b0 || coin_req !== 3'b000) begin
      errors++; $display("FAIL zero c1: busy %b done %b req %b want 1/0/000", busy, done, coin_req); end
    step();
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL zero c2: busy %b done %b want 0/1", busy, done); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero c3 done: got %b want 0", done); end
  endtask

  task automatic test_reject();
    logic [9:0] bad [2];
    bad = '{10'd7, 10'd1000};
    for (int k = 0; k < 2; k++) begin
      amount = bad[k]; start = 1'b1;
      step(); start = 1'b0;
      checks++; if (reject !== 1'b1 || busy !== 1'b0 || remaining !== 10'd0) begin
        errors++; $display("FAIL reject %0d: reject %b busy %b rem %0d want 1/0/0", bad[k], reject, busy, remaining); end
      step();
      checks++; if (reject !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reject %0d next: reject %b busy %b want 0/0", bad[k], reject, busy); end
    end
  endtask

  task automatic test_timeout();
    int held = 0;
    int n = 0;
    amount = 10'd60; start = 1'b1;
    step(); start = 1'b0;
    while (!fault && n < 400) begin
      step(); n++;
      if (!fault && coin_req != 3'b000) held++;
    end
    checks++; if (held != 250) begin errors++; $display("FAIL timeout req cycles: got %0d want 250", held); end
    checks++; if (fault !== 1'b1 || coin_req !== 3'b000 || remaining !== 10'd60 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout state: fault %b req %b rem %0d busy %b want 1/000/60/0", fault, coin_req, remaining, busy); end
    amount = 10'd5; start = 1'b1;
    step(); start = 1'b0;
    checks++; if (fault !== 1'b1 || reject !== 1'b0 || remaining !== 10'd60) begin
      errors++; $display("FAIL timeout start ignored: fault %b reject %b rem %0d want 1/0/60", fault, reject, remaining); end
    clear_fault = 1'b1;
    step(); clear_fault = 1'b0;
    checks++; if (fault !== 1'b0 || busy !== 1'b0 || remaining !== 10'd60) begin
      errors++; $display("FAIL timeout clear: fault %b busy %b rem %0d want 0/0/60", fault, busy, remaining); end
  endtask

  task automatic test_jam();
    int n = 0;
    amount = 10'd60; start = 1'b1;
    step(); start = 1'b0;
    wait_req("jam");
    coin_ack = 1'b1;
    step();
    checks++; if (remaining !== 10'd10 || coin_req !== 3'b000) begin
      errors++; $display("FAIL jam first coin: rem %0d req %b want 10/000", remaining, coin_req); end
    amount = 10'd995; start = 1'b1;
    step(); start = 1'b0; n = 1;
    checks++; if (reject !== 1'b0 || remaining !== 10'd10 || busy !== 1'b1) begin
      errors++; $display("FAIL jam start ignored: reject %b rem %0d busy %b want 0/10/1", reject, remaining, busy); end
    while (!fault && n < 400) begin step(); n++; end
    checks++; if (n != 250) begin errors++; $display("FAIL jam REL cycles: got %0d want 250", n); end
    checks++; if (fault !== 1'b1 || remaining !== 10'd10 || coin_req !== 3'b000 || busy !== 1'b0) begin
      errors++; $display("FAIL jam state: fault %b rem %0d req %b busy %b want 1/10/000/0", fault, remaining, coin_req, busy); end
    coin_ack = 1'b0; clear_fault = 1'b1;
    step(); clear_fault = 1'b0;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL jam clear: fault %b want 0", fault); end
  endtask

  task automatic test_reset_mid();
    amount = 10'd85; start = 1'b1;
    step(); start = 1'b0;
    wait_req("reset_mid");
    #2 reset = 1'b0;
    #1;
    checks++; if (coin_req !== 3'b000 || remaining !== 10'd0 || busy !== 1'b0 || done !== 1'b0 || reject !== 1'b0 || fault !== 1'b0) begin
      errors++; $display("FAIL reset_mid: req %b rem %0d busy %b done %b rej %b fault %b want all 0",
                         coin_req, remaining, busy, done, reject, fault); end
`ifdef COIN_TALLY_EN
    checks++; if (tally_50 !== 8'd0 || tally_10 !== 8'd0 || tally_5 !== 8'd0) begin
      errors++; $display("FAIL reset_mid tally: %0d/%0d/%0d want 0/0/0", tally_50, tally_10, tally_5); end
`endif
    @(negedge clk) reset = 1'b1;
    step(); step();
    checks++; if (busy !== 1'b0 || coin_req !== 3'b000) begin errors++; $display("FAIL reset_mid idle: busy %b req %b want 0/000", busy, coin_req); end
  endtask

`ifdef COIN_TALLY_EN
  task automatic test_tally();
    test_pay85();
    checks++; if (tally_50 !== 8'd1 || tally_10 !== 8'd3 || tally_5 !== 8'd1) begin
      errors++; $display("FAIL tally: %0d/%0d/%0d want 1/3/1", tally_50, tally_10, tally_5); end
  endtask
`endif

  initial begin
    test_reset();
    test_pay85();
    test_zero();
    test_reject();
    test_timeout();
    test_jam();
    test_reset_mid();
`ifdef COIN_TALLY_EN
    test_tally();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
